// File: rtl/cpu_ldm_stm_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg: shared types for the LDM/STM sequencer (states, modes, popcount)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } lsm_state_t;

  localparam logic [1:0] MEM_WIDTH_WORD = 2'h2;

  // Addressing mode is the concatenation {p, u}
  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } lsm_amode_t;

  localparam int POPCOUNT_MAX_W = 64;

  function automatic logic [6:0] popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ldm_stm_seq_prienc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsm_prienc: lowest-set-bit priority encoder with valid flag                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsm_prienc #(
  parameter int NREGS = 16,
  parameter int IDX_W = 4
) (
  input  logic [NREGS-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last (winning) write
  always_comb begin
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    valid = |vec;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_ldm_stm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ldm_stm_seq: LDM/STM block-transfer sequencer on the mem_ok word bus   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_ldm_stm_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [NREGS-1:0]  reg_list,
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  base_idx,
  input  logic              p_bit,
  input  logic              u_bit,
  input  logic              w_bit,
  input  logic              l_bit,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_width,
  input  logic              mem_ok
);

  lsm_state_t        state_q,   state_d;
  logic [NREGS-1:0]  list_q,    list_d;
  logic              load_q,    load_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              wb_en_q,   wb_en_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;

  logic [IDX_W-1:0]  cur_idx;
  logic              cur_valid;
  logic [IDX_W:0]    req_n;
  logic [ADDR_W-1:0] four_n;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] wb_value;
  logic              in_xfer;
  logic              in_done;

  lsm_prienc #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_prienc (
    .vec   (list_q),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  always_comb begin
    req_n    = (IDX_W + 1)'(popcount(POPCOUNT_MAX_W'(reg_list)));
    four_n   = ADDR_W'(req_n) << 2;
    wb_value = u_bit ? (base + four_n) : (base - four_n);
    // Beats always run upward, so descending modes start at the lowest word
    case (lsm_amode_t'({p_bit, u_bit}))
      AM_IA:   start_addr = base;
      AM_IB:   start_addr = base + ADDR_W'(4);
      AM_DA:   start_addr = base - four_n + ADDR_W'(4);
      AM_DB:   start_addr = base - four_n;
      default: start_addr = base;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    load_d    = load_q;
    addr_d    = addr_q;
    wb_en_d   = wb_en_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          list_d    = reg_list;
          load_d    = l_bit;
          addr_d    = {start_addr[ADDR_W-1:2], 2'b00};
          // A base register reloaded by LDM takes priority over writeback
          wb_en_d   = w_bit && !(l_bit && reg_list[base_idx]) && (req_n != '0);
          wb_data_d = wb_value;
          state_d   = (req_n == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (mem_ok && cur_valid) begin
          list_d = list_q & ~(NREGS'(1) << cur_idx);
          addr_d = addr_q + ADDR_W'(4);
          if (list_d == '0) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      list_q    <= '0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    in_xfer   = (state_q == S_XFER);
    in_done   = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    done      = in_done;
    mem_read  = in_xfer && load_q;
    mem_write = in_xfer && !load_q;
    mem_width = MEM_WIDTH_WORD;
    mem_addr  = in_xfer ? addr_q : '0;
    rd_idx    = in_xfer ? cur_idx : '0;
    mem_wdata = mem_write ? rd_data : '0;
    wr_en     = mem_read && mem_ok;
    wr_idx    = wr_en ? cur_idx : '0;
    wr_data   = wr_en ? mem_rdata : '0;
    wb_en     = in_done && wb_en_q;
    wb_data   = in_done ? wb_data_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ldm_stm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_ldm_stm_seq: scoreboard bench for the LDM/STM sequencer             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cpu_ldm_stm_seq;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [NREGS-1:0]  reg_list;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  base_idx;
  logic              p_bit, u_bit, w_bit, l_bit;
  logic              busy, done;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read, mem_write;
  logic [1:0]        mem_width;
  logic              mem_ok;

  cpu_ldm_stm_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .reg_list  (reg_list),
    .base      (base),
    .base_idx  (base_idx),
    .p_bit     (p_bit),
    .u_bit     (u_bit),
    .w_bit     (w_bit),
    .l_bit     (l_bit),
    .busy      (busy),
    .done      (done),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_width (mem_width),
    .mem_ok    (mem_ok)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  idx;
    logic        ld;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic        wb_en;
    logic [31:0] wb_data;
    int          lat;
    int          start_cyc;
  } done_t;

  beat_t       beat_q[$];
  done_t       done_q[$];
  logic [31:0] regs [NREGS];
  logic [31:0] mem_img [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fixed_wait = 0;
  int cur_wait   = 0;
  int wait_cnt   = 0;
  bit wait_rand  = 1'b0;

  assign rd_data = regs[rd_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave: mem_ok after cur_wait stalled cycles per beat, noise when idle
  initial begin
    mem_ok    = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (wait_cnt >= cur_wait) begin
          mem_ok   = 1'b1;
          wait_cnt = 0;
          cur_wait = wait_rand ? int'($urandom_range(0, 3)) : fixed_wait;
        end else begin
          mem_ok   = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ok = 1'($urandom_range(0, 1));
      end
      mem_rdata = rd_mem(mem_addr);
    end
  end

  // Monitor: samples just before each rising edge and pops the scoreboard
  initial begin
    beat_t       b;
    done_t       d;
    logic        strobe;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        prev_rd;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_rd    = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      strobe = mem_read || mem_write;
      if (strobe && !busy) check("strobe_while_idle", 1'b1, 1'b0);
      if (strobe && prev_stall) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_read", mem_read, prev_rd);
      end
      if (strobe && mem_ok) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr", mem_addr, b.addr);
          check("beat_read", mem_read, b.ld);
          check("beat_write", mem_write, !b.ld);
          check("mem_width", mem_width, 2'h2);
          if (b.ld) begin
            check("wr_en", wr_en, 1'b1);
            check("wr_idx", wr_idx, b.idx);
            check("wr_data", wr_data, b.data);
          end else begin
            check("rd_idx", rd_idx, b.idx);
            check("mem_wdata", mem_wdata, b.data);
            check("wr_en_store", wr_en, 1'b0);
          end
        end
      end else if (wr_en) begin
        check("stray_wr_en", wr_en, 1'b0);
      end
      if (done) begin
        check("done_no_strobe", strobe, 1'b0);
        if (done_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          d = done_q.pop_front();
          check("wb_en", wb_en, d.wb_en);
          check("wb_data", wb_data, d.wb_data);
          if (d.lat >= 0) check("done_latency", 64'(cyc - d.start_cyc), 64'(d.lat));
        end
      end else if (wb_en) begin
        check("stray_wb_en", wb_en, 1'b0);
      end
      prev_stall = strobe && !mem_ok;
      prev_addr  = mem_addr;
      prev_rd    = mem_read;
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || done) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic set_wait(input bit rnd, input int w);
    wait_idle();
    wait_rand  = rnd;
    fixed_wait = w;
    cur_wait   = rnd ? int'($urandom_range(0, 3)) : w;
    wait_cnt   = 0;
  endtask

  task automatic scramble();
    reg_list = 16'($urandom);
    base     = $urandom;
    base_idx = 4'($urandom);
    {p_bit, u_bit, w_bit, l_bit} = 4'($urandom);
  endtask

  // Reference model: beats in ascending register order from the lowest block address
  task automatic issue(input logic [15:0] list, input logic [31:0] b, input logic [3:0] bidx,
                       input logic p, input logic u, input logic w, input logic l,
                       input bit lat_chk, input bit abort);
    int          n, k;
    logic [31:0] fn, lo;
    beat_t       bt;
    done_t       dn;
    wait_idle();
    n  = $countones(list);
    fn = 32'(4 * n);
    lo = u ? (b + (p ? 32'd4 : 32'd0)) : (b - fn + (p ? 32'd0 : 32'd4));
    k  = 0;
    for (int i = 0; i < NREGS; i++) begin
      if (list[i]) begin
        bt.addr = (lo + 32'(4 * k)) & 32'hFFFF_FFFC;
        bt.idx  = 4'(i);
        bt.ld   = l;
        bt.data = l ? rd_mem(bt.addr) : regs[i];
        if (!abort || k == 0) beat_q.push_back(bt);
        k++;
      end
    end
    dn.wb_en     = w && !(l && list[bidx]) && (n != 0);
    dn.wb_data   = u ? (b + fn) : (b - fn);
    dn.lat       = !lat_chk ? -1 : ((n == 0) ? 1 : n * (fixed_wait + 1) + 1);
    dn.start_cyc = cyc;
    if (!abort) done_q.push_back(dn);
    reg_list = list;
    base     = b;
    base_idx = bidx;
    p_bit = p; u_bit = u; w_bit = w; l_bit = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic poke_busy();
    @(negedge clk);
    if (busy) begin
      scramble();
      reg_list = 16'hFFFF;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
    end
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    scramble();
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 32'h11);
    repeat (3) @(negedge clk);
    #4;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_wr_idx_data", {wr_idx, wr_data}, 36'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_rd_idx", rd_idx, 4'h0);
    @(negedge clk);
    rstn = 1'b1;

    // STMIA, three registers, no waits
    set_wait(1'b0, 0);
    issue(16'h000E, 32'h0300_0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    poke_busy();

    // LDMDB r0, r15
    mem_img[32'h0300_0008] = 32'h0000_00A0;
    mem_img[32'h0300_000C] = 32'h0000_00B0;
    issue(16'h8001, 32'h0300_0010, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // STMIB with three wait cycles per beat
    set_wait(1'b0, 3);
    issue(16'h0003, 32'h0200_0100, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // LDMIA with the base in the list suppresses writeback
    set_wait(1'b0, 0);
    issue(16'h0006, 32'h0100_0040, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Empty list
    issue(16'h0000, 32'h0500_0000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    check("empty_busy_c2", busy, 1'b0);

    // STM with the base in the list stores the original base
    regs[3] = 32'h0600_0020;
    issue(16'h0018, 32'h0600_0020, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomised transfers
    for (int t = 0; t < 80; t++) begin
      logic [15:0] lst;
      bit          rnd;
      logic [3:0]  flags;
      case ($urandom_range(0, 7))
        0:       lst = 16'h0000;
        1:       lst = 16'hFFFF;
        2:       lst = 16'(1 << $urandom_range(0, 15));
        default: lst = 16'($urandom) & 16'($urandom);
      endcase
      rnd   = 1'($urandom_range(0, 1));
      flags = 4'($urandom);
      set_wait(rnd, int'($urandom_range(0, 2)));
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      issue(lst, $urandom, 4'($urandom), flags[3], flags[2], flags[1], flags[0], !rnd, 1'b0);
      if ($urandom_range(0, 3) == 0) poke_busy();
    end

    // Reset after the first beat of a 4-register STM
    set_wait(1'b0, 0);
    issue(16'h00F0, 32'h0400_0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    #4;
    check("abort_busy", busy, 1'b0);
    check("abort_strobes", {mem_read, mem_write}, 2'b00);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    set_wait(1'b0, 0);

    repeat (4) @(negedge clk);
    check("beat_q_drained", 64'(beat_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
